// File: rtl/processor.sv
// Single-cycle 16-opcode core with a 16-entry register file and a
// registered general-purpose output port.
// Ports:
//   clk      - sole clock, all state commits on the rising edge
//   rst_n    - asynchronous active-low reset (PC, registers, pin_out to 0)
//   pc       - current program counter (instruction fetch address)
//   ins      - 16-bit instruction at pc, supplied combinationally
//   pin_in   - general-purpose input pins, sampled by IN
//   pin_out  - general-purpose output pins, written only by OUT
module processor #(
  parameter int unsigned BITNESS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [BITNESS-1:0] pc,
  input  logic [15:0]        ins,
  input  logic [BITNESS-1:0] pin_in,
  output logic [BITNESS-1:0] pin_out
);

  localparam int unsigned NREGS = 16;

  typedef enum logic [3:0] {
    OP_LDI = 4'h0, OP_LUI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_OUT = 4'h6, OP_IN  = 4'h7,
    OP_XOR = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_JMP = 4'hB,
    OP_BZ  = 4'hC, OP_BNZ = 4'hD, OP_BRA = 4'hE, OP_HLT = 4'hF
  } op_t;

  logic [BITNESS-1:0] regs [NREGS];

  op_t                op;
  logic [3:0]         rd, ra, rb;
  logic [7:0]         imm8;
  logic [11:0]        off12;
  logic [BITNESS-1:0] rd_val, ra_val, rb_val;

  logic [BITNESS-1:0] pc_nxt;
  logic [BITNESS-1:0] pin_nxt;
  logic               wr_en;
  logic [BITNESS-1:0] wr_data;
  logic [BITNESS-1:0] seq_pc;
  logic [BITNESS-1:0] lui_val;

  // Instruction field decode.
  always_comb begin
    op     = op_t'(ins[15:12]);
    rd     = ins[11:8];
    ra     = ins[7:4];
    rb     = ins[3:0];
    imm8   = ins[7:0];
    off12  = ins[11:0];
    rd_val = regs[rd];
    ra_val = regs[ra];
    rb_val = regs[rb];
  end

  // Execute: next PC, register write-back and pin_out for this cycle.
  always_comb begin
    seq_pc  = pc + BITNESS'(1);
    pc_nxt  = seq_pc;
    pin_nxt = pin_out;
    wr_en   = 1'b0;
    wr_data = '0;
    lui_val = rd_val;
    lui_val[15:8] = imm8;
    unique case (op)
      OP_LDI: begin wr_en = 1'b1; wr_data = BITNESS'(imm8); end
      OP_LUI: begin wr_en = 1'b1; wr_data = lui_val; end
      OP_ADD: begin wr_en = 1'b1; wr_data = ra_val + rb_val; end
      OP_SUB: begin wr_en = 1'b1; wr_data = ra_val - rb_val; end
      OP_AND: begin wr_en = 1'b1; wr_data = ra_val & rb_val; end
      OP_OR:  begin wr_en = 1'b1; wr_data = ra_val | rb_val; end
      OP_XOR: begin wr_en = 1'b1; wr_data = ra_val ^ rb_val; end
      OP_OUT: pin_nxt = rb_val;
      OP_IN:  begin wr_en = 1'b1; wr_data = pin_in; end
      OP_SHL: begin wr_en = 1'b1; wr_data = ra_val << 1; end
      OP_SHR: begin wr_en = 1'b1; wr_data = ra_val >> 1; end
      OP_JMP: pc_nxt = ra_val;
      OP_BZ:  pc_nxt = (rd_val == '0) ? ra_val : seq_pc;
      OP_BNZ: pc_nxt = (rd_val != '0) ? ra_val : seq_pc;
      OP_BRA: pc_nxt = pc + {{(BITNESS-12){off12[11]}}, off12};
      OP_HLT: pc_nxt = pc;
      default: ;
    endcase
  end

  // Architectural state commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      pin_out <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      pc      <= pc_nxt;
      pin_out <= pin_nxt;
      if (wr_en) regs[rd] <= wr_data;
    end
  end

endmodule

// File: tb/tb_processor.sv
// Testbench for processor: directed programs plus random programs
// checked every cycle against an instruction-level reference model.
module tb_processor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic [15:0] ins;
  logic [15:0] pin_in = 16'h0000;
  logic [15:0] pin_out;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_pc;
  int m_pin;
  int m_r [16];

  always #5 clk = ~clk;

  assign ins = mem[pc];

  processor #(.BITNESS(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .ins(ins),
    .pin_in(pin_in), .pin_out(pin_out)
  );

  task automatic model_reset();
    m_pc = 0;
    m_pin = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
  endtask

  // Executes one instruction in the model from the word at m_pc.
  task automatic model_exec();
    int w, op, rd, ra, rb, a, b, d, npc, off;
    w  = int'(mem[m_pc[15:0]]);
    op = (w >> 12) & 15;
    rd = (w >> 8) & 15;
    ra = (w >> 4) & 15;
    rb = w & 15;
    a  = m_r[ra];
    b  = m_r[rb];
    d  = m_r[rd];
    npc = (m_pc + 1) % 65536;
    case (op)
      0:  m_r[rd] = w & 255;
      1:  m_r[rd] = (d & 255) | ((w & 255) << 8);
      2:  m_r[rd] = (a + b) % 65536;
      3:  m_r[rd] = (a - b + 65536) % 65536;
      4:  m_r[rd] = a & b;
      5:  m_r[rd] = a | b;
      6:  m_pin = b;
      7:  m_r[rd] = int'(pin_in);
      8:  m_r[rd] = a ^ b;
      9:  m_r[rd] = (a * 2) % 65536;
      10: m_r[rd] = a / 2;
      11: npc = a;
      12: if (d == 0) npc = a;
      13: if (d != 0) npc = a;
      14: begin
        off = w & 4095;
        if (off >= 2048) off = off - 4096;
        npc = (m_pc + off + 65536) % 65536;
      end
      default: npc = m_pc;
    endcase
    m_pc = npc;
  endtask

  // One clock: model advances, DUT commits, outputs sampled 1 time unit later.
  task automatic step();
    model_exec();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic test_reset();
    clear_mem();
    model_reset();
    #3;
    checks++;
    if (pc !== 16'h0000) begin
      $display("FAIL reset_pc: got %h want 0000", pc); errors++;
    end
    checks++;
    if (pin_out !== 16'h0000) begin
      $display("FAIL reset_pin_out: got %h want 0000", pin_out); errors++;
    end
    @(posedge clk); #1;
    checks++;
    if (pc !== 16'h0000) begin
      $display("FAIL reset_hold_pc: got %h want 0000", pc); errors++;
    end
    pulse_reset();
  endtask

  // Two-word program: LDI R0,0x6F then OUT R0, followed by zeros.
  task automatic test_ldi_out();
    clear_mem();
    mem[0] = 16'h006F;
    mem[1] = 16'h6F10;
    pin_in = 16'hFFFF;
    pulse_reset();
    step();
    checks++;
    if (pc !== 16'h0001 || pin_out !== 16'h0000) begin
      $display("FAIL ldi_edge1: got pc=%h pin=%h want 0001/0000", pc, pin_out); errors++;
    end
    step();
    checks++;
    if (pc !== 16'h0002 || pin_out !== 16'h006F) begin
      $display("FAIL out_edge2: got pc=%h pin=%h want 0002/006f", pc, pin_out); errors++;
    end
    step();
    checks++;
    if (m_r[0] != 0 || pc !== 16'h0003) begin
      $display("FAIL ldi0_edge3: got pc=%h model_r0=%0d want 0003/0", pc, m_r[0]); errors++;
    end
  endtask

  task automatic test_in_add();
    clear_mem();
    mem[0] = 16'h7100;
    mem[1] = 16'h2211;
    mem[2] = 16'h6002;
    pin_in = 16'hFFFF;
    pulse_reset();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (pin_out !== 16'hFFFE || pc !== 16'h0003) begin
      $display("FAIL in_add_out: got pc=%h pin=%h want 0003/fffe", pc, pin_out); errors++;
    end
  endtask

  task automatic test_lui();
    clear_mem();
    mem[0] = 16'h0334;
    mem[1] = 16'h1312;
    mem[2] = 16'h6003;
    pulse_reset();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (pin_out !== 16'h1234) begin
      $display("FAIL lui_out: got %h want 1234", pin_out); errors++;
    end
  endtask

  task automatic test_branches();
    clear_mem();
    mem[16'h0000] = 16'h0110; // LDI R1,0x10
    mem[16'h0001] = 16'hC010; // BZ R0,R1 -> taken
    mem[16'h0010] = 16'hD010; // BNZ R0,R1 -> not taken
    mem[16'h0011] = 16'h0205; // LDI R2,5
    mem[16'h0012] = 16'hB020; // JMP R2
    mem[16'h0005] = 16'hEFFF; // BRA -1
    pulse_reset();
    step(); step();
    checks++;
    if (pc !== 16'h0010) begin
      $display("FAIL bz_taken: got %h want 0010", pc); errors++;
    end
    step();
    checks++;
    if (pc !== 16'h0011) begin
      $display("FAIL bnz_not_taken: got %h want 0011", pc); errors++;
    end
    step(); step();
    checks++;
    if (pc !== 16'h0005) begin
      $display("FAIL jmp: got %h want 0005", pc); errors++;
    end
    step();
    checks++;
    if (pc !== 16'h0004) begin
      $display("FAIL bra_back: got %h want 0004", pc); errors++;
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 16'h04FF; // LDI R4,0xFF
    mem[1] = 16'h14FF; // LUI R4,0xFF
    mem[2] = 16'h0501; // LDI R5,1
    mem[3] = 16'h6004; // OUT R4
    mem[4] = 16'h2645; // ADD R6,R4,R5
    mem[5] = 16'h6006; // OUT R6
    mem[6] = 16'hB040; // JMP R4 -> 0xFFFF
    mem[16'hFFFF] = 16'h0000;
    pulse_reset();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (pin_out !== 16'hFFFF) begin
      $display("FAIL wrap_ones: got %h want ffff", pin_out); errors++;
    end
    step(); step();
    checks++;
    if (pin_out !== 16'h0000) begin
      $display("FAIL add_wrap: got %h want 0000", pin_out); errors++;
    end
    step();
    checks++;
    if (pc !== 16'hFFFF) begin
      $display("FAIL jmp_top: got %h want ffff", pc); errors++;
    end
    step();
    checks++;
    if (pc !== 16'h0000) begin
      $display("FAIL pc_wrap: got %h want 0000", pc); errors++;
    end
  endtask

  task automatic test_halt();
    bit held;
    clear_mem();
    mem[0] = 16'h015A; // LDI R1,0x5A
    mem[1] = 16'h6001; // OUT R1
    mem[7] = 16'hF000;
    pulse_reset();
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (pc !== 16'h0007 || pin_out !== 16'h005A) begin
      $display("FAIL halt_reach: got pc=%h pin=%h want 0007/005a", pc, pin_out); errors++;
    end
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pc !== 16'h0007 || pin_out !== 16'h005A) held = 1'b0;
    end
    checks++;
    if (!held) begin
      $display("FAIL halt_hold: got pc=%h pin=%h want 0007/005a", pc, pin_out); errors++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 16'h0000 || pin_out !== 16'h0000) begin
      $display("FAIL async_reset: got pc=%h pin=%h want 0000/0000", pc, pin_out); errors++;
    end
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Random programs, random pin_in, occasional mid-program reset.
  task automatic test_random();
    logic [15:0] w;
    int bad = 0;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h6;
      mem[i] = w;
    end
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) pulse_reset();
      pin_in = 16'($urandom);
      step();
      checks++;
      if (pc !== 16'(m_pc) || pin_out !== 16'(m_pin)) begin
        errors++;
        if (bad < 5)
          $display("FAIL random_cycle%0d: got pc=%h pin=%h want %h/%h",
                   c, pc, pin_out, 16'(m_pc), 16'(m_pin));
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ldi_out();
    test_in_add();
    test_lui();
    test_branches();
    test_wrap();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter BITNESS, default 16, datapath/PC/pin width; SHALL be >= 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 pc  output  BITNESS  current program-counter register value (instruction fetch address).
REQ-005 ins  input  16  instruction word at address pc, supplied combinationally by external memory.
REQ-006 pin_in  input  BITNESS  general-purpose input pins.
REQ-007 pin_out  output  BITNESS  general-purpose output pins, registered.

Function
REQ-008 Single-cycle core: ins decoded combinationally from current pc; PC, register-file and pin_out updates commit at the same rising clk edge; one instruction retires per cycle.
REQ-009 State: PC, 16 general registers R0..R15 (BITNESS wide, R0 ordinary/writable), pin_out register.
REQ-010 Fields: op=ins[15:12], rd=ins[11:8], ra=ins[7:4], rb=ins[3:0], imm8=ins[7:0], off12=ins[11:0].
REQ-011 Default next PC = PC+1, modulo 2^BITNESS (wraps from all-ones to 0).
REQ-012 op 0 LDI: R[rd] = zero-extended imm8.
REQ-013 op 1 LUI: R[rd][15:8] = imm8, other bits of R[rd] unchanged.
REQ-014 op 2 ADD, 3 SUB, 4 AND, 5 OR, 8 XOR: R[rd] = R[ra] op R[rb]; ADD/SUB wrap modulo 2^BITNESS, no flags.
REQ-015 op 6 OUT: pin_out = R[rb]; ins[11:4] ignored; registers unchanged.
REQ-016 op 7 IN: R[rd] = pin_in sampled at the executing edge; ins[7:0] ignored.
REQ-017 op 9 SHL: R[rd] = R[ra] << 1; op A SHR: R[rd] = R[ra] >> 1 (logical, zero fill); rb ignored.
REQ-018 op B JMP: next PC = R[ra].
REQ-019 op C BZ: next PC = R[ra] if R[rd]==0, else PC+1; op D BNZ: next PC = R[ra] if R[rd]!=0, else PC+1.
REQ-020 op E BRA: next PC = PC + sign-extended off12, modulo 2^BITNESS (0xE000 loops in place).
REQ-021 op F HALT: PC, registers, pin_out hold while ins stays 0xF000-class; leaves only via reset.
REQ-022 Operands read before the edge's write: rd==ra/rb uses old value (e.g. ADD R1,R1,R1 doubles R1).
REQ-023 pin_out changes only on OUT or reset; all other instructions keep it.
REQ-024 No X propagation: every opcode fully defined; unused fields never affect results.

Reset
REQ-025 rst_n low asynchronously forces PC=0, R0..R15=0, pin_out=0, regardless of clk.
REQ-026 While rst_n low no instruction executes; first instruction (address 0) executes on first rising clk with rst_n high.
REQ-027 Reset asserted mid-program aborts the current instruction (no partial commit) and restarts at address 0.

Verification
REQ-028 Mem[0]=0x006F, mem[1]=0x6F10, rest 0x0000, pin_in all ones -> after edge 1 pc=1, R0=0x006F, pin_out=0; after edge 2 pc=2, pin_out=0x006F (bit0=1); edge 3 R0=0.
REQ-029 pin_in=0xFFFF; program 0x7100 (IN R1), 0x2211 (ADD R2,R1,R1), 0x6002 (OUT R2) -> pin_out=0xFFFE after 3rd edge, pc=3.
REQ-030 LDI R3,0x34 (0x0334) then LUI R3,0x12 (0x1312) then OUT R3 (0x6003) -> pin_out=0x1234.
REQ-031 Branches: R0=0, R1=0x0010; BZ R0,R1 (0xC010) -> pc=0x10; BNZ R0,R1 (0xD010) -> pc+1; BRA 0xEFFF at pc=5 -> pc=4; ADD 0xFFFF+1 -> 0.
REQ-032 HALT 0xF000 at pc=7 -> pc stays 7 for 10 edges; rst_n pulse low between edges -> pc=0, pin_out=0 immediately, before next edge.
